sd_stream_collector: RTL and testbench
======================================

Name: sd_stream_collector

Overview:
- Receive-side companion of the online signed-digit multiplier.
- Consumes the MSD-first stream of 2-bit signed digits the multiplier emits on p_value (data_out_vld/data_out_rdy side).
- Converts each frame of NUM_DIGITS digits on the fly into a two's-complement word and presents it on a word-level valid/ready handshake.
- Sits between the multiplier output and the binary result sink / next pipeline stage.

Parameters:
- NUM_DIGITS, 32: digits per frame; result integer = sum d_i * 2^(NUM_DIGITS-i), i = 1..NUM_DIGITS.
- CNT_WIDTH, 6: digit counter width; must satisfy 2^CNT_WIDTH > NUM_DIGITS.

Ports:
- clk  input  1  system clock, rising edge.
- asyn_reset  input  1  asynchronous active-high reset.
- p_value  input  2  signed digit: {plus, minus}. 10 = +1, 01 = -1, 00 = 0, 11 = illegal (treated as 0).
- data_in_vld  input  1  p_value valid; connects to multiplier data_out_vld.
- data_in_rdy  output  1  collector can accept a digit; connects to multiplier data_out_rdy.
- word_out  output  NUM_DIGITS+1  two's-complement result of the completed frame.
- word_out_vld  output  1  word_out valid.
- word_out_rdy  input  1  downstream accepts word_out.
- digit_cnt  output  CNT_WIDTH  digits accepted in the current frame.
- illegal_digit  output  1  sticky flag: an 11 digit was accepted in the current or held frame.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-high (asyn_reset).
- Reset values: state IDLE, data_in_rdy 0, word_out 0, word_out_vld 0, digit_cnt 0, illegal_digit 0, Q 0, QM all-ones (-1).
- data_in_rdy is registered. It rises on the first clk edge after reset deasserts and is 1 in IDLE/COLLECT, 0 in HOLD.
- A digit is accepted on a clk edge with data_in_vld & data_in_rdy. No other edge changes Q, QM or digit_cnt.
- States:
  - IDLE: accept → COLLECT with digit_cnt = 1. If NUM_DIGITS = 1, go straight to HOLD.
  - COLLECT: each accept increments digit_cnt. The accept that makes digit_cnt = NUM_DIGITS → HOLD.
  - HOLD: word_out_vld = 1. On word_out_vld & word_out_rdy → IDLE, with digit_cnt 0, Q 0, QM -1, illegal_digit 0.
- No digit is accepted in HOLD. One bubble per frame is required behaviour, not a bug.
- Latency: word_out_vld asserts the cycle after the final digit is accepted. word_out equals the final Q on that same cycle.
- On-the-fly conversion, N+1-bit two's complement, per accepted digit d:
  - d = +1: Q ← 2Q+1; QM ← 2Q.
  - d = 0: Q ← 2Q; QM ← 2QM+1.
  - d = -1: Q ← 2QM+1; QM ← 2QM.
  - Invariant: QM = Q - 1 after every accept.
  - No carry-propagate adder is permitted; shifts and bit appends only.
- Range and width:
  - Result range is -(2^N - 1) .. +(2^N - 1); it always fits in N+1 bits.
  - The MSB of word_out is the sign bit. Bits shifted out of position N are discarded.
- word_out and illegal_digit are stable while word_out_vld = 1, regardless of p_value or data_in_vld activity.
- data_in_vld without data_in_rdy (HOLD) has no effect. The upstream holds its digit per protocol.
- word_out_rdy held high in HOLD: handshake completes on the first HOLD cycle, giving two cycles from last digit to next accept.
- word_out_rdy while not in HOLD is ignored.
- Reset mid-frame: immediate return to reset values. Partial frame discarded; no word_out_vld pulse.
- digit_cnt never exceeds NUM_DIGITS and never wraps.

Test Plan:
- NUM_DIGITS = 4, digits +1, 0, -1, +1 back-to-back, word_out_rdy = 1 → word_out = 5'b00111 (+7) one cycle after the 4th accept; vld high for 1 cycle; data_in_rdy low exactly 1 cycle.
- NUM_DIGITS = 4, digits -1, +1, 0, 0 → 5'b11100 (-4). Digits -1 ×4 → 5'b10001 (-15). Digits +1 ×4 → 5'b01111 (+15). Digits 0 ×4 → 5'b00000.
- Backpressure: complete frame +1, 0, -1, +1, hold word_out_rdy = 0 for 10 cycles while data_in_vld = 1 with changing p_value → data_in_rdy = 0, word_out stays 5'b00111, no digit consumed. Release → next frame starts cleanly.
- Random data_in_vld gaps (50% duty) over 200 random frames → each word_out equals the reference sum of d_i * 2^(4-i); digit_cnt sequence 1..4 per frame.
- Frame containing digit 11 (e.g. +1, 11, 0, -1) → treated as 0, word_out = 5'b00111, illegal_digit = 1 in HOLD. Flag cleared after the handshake.
- Assert asyn_reset after 2 of 4 digits → all outputs return to reset values asynchronously. After release, a full frame 0, 0, 0, +1 → 5'b00001 with no stale bits.

Source files
------------

// File: rtl/sd_stream_collector.sv
// sd_stream_collector
//   Receive side of the online signed-digit multiplier. Takes the MSD-first
//   stream of {plus,minus} digits and builds a NUM_DIGITS+1 bit two's-complement
//   word with on-the-fly conversion (Q / QM = Q-1 pair, shifts and appends
//   only). The word is offered on a valid/ready handshake. No digit is taken
//   while a word is held, so every frame costs one bubble.
//
// Ports
//   clk           system clock, rising edge
//   asyn_reset    asynchronous reset, active high
//   p_value       signed digit {plus,minus}: 10=+1, 01=-1, 00=0, 11=illegal (as 0)
//   data_in_vld   digit valid (from multiplier data_out_vld)
//   data_in_rdy   digit accept (to multiplier data_out_rdy), registered
//   word_out      converted frame, sign in MSB
//   word_out_vld  word_out valid (HOLD state)
//   word_out_rdy  downstream accepts word_out
//   digit_cnt     digits accepted in the current frame
//   illegal_digit sticky: an 11 digit was accepted in this frame
module sd_stream_collector #(
  parameter int NUM_DIGITS = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  asyn_reset,
  input  logic [1:0]            p_value,
  input  logic                  data_in_vld,
  output logic                  data_in_rdy,
  output logic [NUM_DIGITS:0]   word_out,
  output logic                  word_out_vld,
  input  logic                  word_out_rdy,
  output logic [CNT_WIDTH-1:0]  digit_cnt,
  output logic                  illegal_digit
);

  localparam int N = NUM_DIGITS;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t      state_q, state_n;
  logic [N:0]  q, qm;
  logic        acc, hs, d_plus, d_minus;

  assign acc     = data_in_vld & data_in_rdy;
  assign hs      = (state_q == HOLD) & word_out_rdy;
  // 11 decodes to neither plus nor minus, i.e. it behaves as a zero digit.
  assign d_plus  = p_value[1] & ~p_value[0];
  assign d_minus = p_value[0] & ~p_value[1];

  assign word_out     = q;
  assign word_out_vld = (state_q == HOLD);

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE, COLLECT: if (acc) state_n = (digit_cnt == LAST) ? HOLD : COLLECT;
      HOLD:          if (word_out_rdy) state_n = IDLE;
      default:       state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state_q     <= IDLE;
      data_in_rdy <= 1'b0;
    end else begin
      state_q     <= state_n;
      // Registered ready tracks the state being entered, so it drops on the
      // same edge that takes the last digit.
      data_in_rdy <= (state_n != HOLD);
    end
  end

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      q             <= '0;
      qm            <= '1;
      digit_cnt     <= '0;
      illegal_digit <= 1'b0;
    end else if (acc) begin
      // Both candidates only shift left and append a bit; the top bit
      // shifted out of position N is dropped since the result fits N+1 bits.
      if (d_plus) begin
        q  <= {q[N-1:0], 1'b1};
        qm <= {q[N-1:0], 1'b0};
      end else if (d_minus) begin
        q  <= {qm[N-1:0], 1'b1};
        qm <= {qm[N-1:0], 1'b0};
      end else begin
        q  <= {q[N-1:0], 1'b0};
        qm <= {qm[N-1:0], 1'b1};
      end
      digit_cnt <= digit_cnt + 1'b1;
      if (p_value == 2'b11) illegal_digit <= 1'b1;
    end else if (hs) begin
      q             <= '0;
      qm            <= '1;
      digit_cnt     <= '0;
      illegal_digit <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sd_stream_collector.sv
module tb_sd_stream_collector;

  localparam int ND = 4;
  localparam int CW = 3;

  logic          clk, asyn_reset;
  logic [1:0]    p_value;
  logic          data_in_vld, data_in_rdy;
  logic [ND:0]   word_out;
  logic          word_out_vld, word_out_rdy;
  logic [CW-1:0] digit_cnt;
  logic          illegal_digit;

  int n_cmp = 0;
  int n_err = 0;

  sd_stream_collector #(.NUM_DIGITS(ND), .CNT_WIDTH(CW)) dut (
    .clk(clk), .asyn_reset(asyn_reset), .p_value(p_value),
    .data_in_vld(data_in_vld), .data_in_rdy(data_in_rdy),
    .word_out(word_out), .word_out_vld(word_out_vld), .word_out_rdy(word_out_rdy),
    .digit_cnt(digit_cnt), .illegal_digit(illegal_digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Present one digit and hold it until accepted; returns at posedge+1 after
  // the accepting edge. Optional random idle cycles before presenting.
  task automatic send(input logic [1:0] d, input bit gap);
    int n;
    n = 0;
    if (gap) while ($urandom_range(0, 1) == 1 && n < 8) begin
      @(posedge clk); #1; n++;
    end
    p_value = d; data_in_vld = 1'b1; n = 0;
    while (!data_in_rdy && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("rdy_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    data_in_vld = 1'b0;
  endtask

  // Full frame with word_out_rdy high: checks HOLD contents, then the
  // single-cycle handshake and return to an empty frame.
  task automatic frame(input string tag, input logic [7:0] ds, input logic [4:0] exp,
                       input bit ill, input bit gap);
    for (int i = 0; i < ND; i++) begin
      send(ds[7-2*i -: 2], gap);
      chk({tag, "_cnt"}, 32'(digit_cnt), 32'(i + 1));
    end
    chk({tag, "_vld"}, 32'(word_out_vld), 32'd1);
    chk({tag, "_word"}, 32'(word_out), 32'(exp));
    chk({tag, "_rdy_lo"}, 32'(data_in_rdy), 32'd0);
    chk({tag, "_ill"}, 32'(illegal_digit), 32'(ill));
    @(posedge clk); #1;
    chk({tag, "_vld_lo"}, 32'(word_out_vld), 32'd0);
    chk({tag, "_rdy_hi"}, 32'(data_in_rdy), 32'd1);
    chk({tag, "_cnt0"}, 32'(digit_cnt), 32'd0);
    chk({tag, "_ill0"}, 32'(illegal_digit), 32'd0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_rdy"}, 32'(data_in_rdy), 32'd0);
    chk({tag, "_vld"}, 32'(word_out_vld), 32'd0);
    chk({tag, "_word"}, 32'(word_out), 32'd0);
    chk({tag, "_cnt"}, 32'(digit_cnt), 32'd0);
    chk({tag, "_ill"}, 32'(illegal_digit), 32'd0);
  endtask

  initial begin
    logic [7:0] ds;
    int         rv, code;

    asyn_reset = 1'b0; p_value = 2'b00; data_in_vld = 1'b0; word_out_rdy = 1'b1;
    #3 asyn_reset = 1'b1;
    #1 reset_checks("rst");
    @(posedge clk); #1;
    reset_checks("rst_hold");
    @(negedge clk); asyn_reset = 1'b0;
    @(posedge clk); #1;
    chk("rdy_after_rst", 32'(data_in_rdy), 32'd1);

    // Directed frames, back-to-back digits
    frame("f_p0mp", 8'b10_00_01_10, 5'b00111, 1'b0, 1'b0);   // +7
    frame("f_mp00", 8'b01_10_00_00, 5'b11100, 1'b0, 1'b0);   // -4
    frame("f_mmmm", 8'b01_01_01_01, 5'b10001, 1'b0, 1'b0);   // -15
    frame("f_pppp", 8'b10_10_10_10, 5'b01111, 1'b0, 1'b0);   // +15
    frame("f_0000", 8'b00_00_00_00, 5'b00000, 1'b0, 1'b0);   // 0
    frame("f_ill",  8'b10_11_00_01, 5'b00111, 1'b1, 1'b0);   // 11 as 0 -> +7

    // Backpressure: word held, input traffic ignored
    word_out_rdy = 1'b0;
    send(2'b10, 1'b0); send(2'b00, 1'b0); send(2'b01, 1'b0); send(2'b10, 1'b0);
    for (int c = 0; c < 10; c++) begin
      data_in_vld = 1'b1; p_value = 2'(c);
      @(posedge clk); #1;
      chk("bp_rdy", 32'(data_in_rdy), 32'd0);
      chk("bp_vld", 32'(word_out_vld), 32'd1);
      chk("bp_word", 32'(word_out), 32'b00111);
      chk("bp_cnt", 32'(digit_cnt), 32'd4);
    end
    data_in_vld = 1'b0;
    word_out_rdy = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_vld", 32'(word_out_vld), 32'd0);
    chk("bp_release_cnt", 32'(digit_cnt), 32'd0);
    frame("f_after_bp", 8'b01_00_10_00, 5'b11010, 1'b0, 1'b0); // -8+2 = -6

    // Random frames with random input gaps
    for (int f = 0; f < 200; f++) begin
      rv = 0;
      for (int i = 0; i < ND; i++) begin
        code = $urandom_range(0, 2);
        ds[7-2*i -: 2] = (code == 1) ? 2'b10 : (code == 2) ? 2'b01 : 2'b00;
        rv += ((code == 1) ? 1 : (code == 2) ? -1 : 0) * (8 >> i);
      end
      frame("rnd", ds, 5'(rv), 1'b0, 1'b1);
    end

    // Reset mid-frame, after two digits (one illegal)
    send(2'b11, 1'b0); send(2'b10, 1'b0);
    chk("mid_cnt", 32'(digit_cnt), 32'd2);
    chk("mid_ill", 32'(illegal_digit), 32'd1);
    #2 asyn_reset = 1'b1;
    #1 reset_checks("mid_rst");
    @(negedge clk); asyn_reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_rdy", 32'(data_in_rdy), 32'd1);
    frame("f_after_rst", 8'b00_00_00_10, 5'b00001, 1'b0, 1'b0);
    frame("f_m_first", 8'b01_00_00_00, 5'b11000, 1'b0, 1'b0);   // -8

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
